// File: rtl/present_dec_pkg.sv
// ============================================================================
// Module   : present_dec_pkg
// Brief    : Shared types, constants and inverse S-box helper for the
//            PRESENT-style decryption core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package present_dec_pkg;

  localparam int BLOCK_W = 64;
  localparam int NIBBLES = 16;

  localparam logic [3:0] INV_SBOX [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  function automatic logic [BLOCK_W-1:0] inv_sbox64(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    r = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      r[4*n +: 4] = INV_SBOX[s[4*n +: 4]];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/present_dec_core_inv_player.sv
// ============================================================================
// Module   : inv_player
// Brief    : Combinational inverse PRESENT bit permutation
//            (bit j -> bit 4*j mod 63, bit 63 fixed).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inv_player
  import present_dec_pkg::*;
(
  input  logic [BLOCK_W-1:0] din,
  output logic [BLOCK_W-1:0] dout
);

  for (genvar j = 0; j < BLOCK_W-1; j++) begin : g_bit
    assign dout[(4*j) % (BLOCK_W-1)] = din[j];
  end

  assign dout[BLOCK_W-1] = din[BLOCK_W-1];

endmodule

`default_nettype wire

// File: rtl/present_dec_core.sv
// ============================================================================
// Module   : present_dec_core
// Brief    : Iterative PRESENT-style decryptor, one inverse round per clock.
//            Optional macro PRESENT_DEC_ZEROIZE_EN clears the result after
//            handoff and masks out_data outside DONE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module present_dec_core
  import present_dec_pkg::*;
#(
  parameter int NUM_ROUNDS = 31,
  parameter int KIDX_W     = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic [KIDX_W-1:0]  key_idx,
  input  logic [BLOCK_W-1:0] key_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data
);

  localparam logic [KIDX_W-1:0] c_kidx_first = KIDX_W'(NUM_ROUNDS + 1);
  localparam logic [KIDX_W-1:0] c_kidx_run   = KIDX_W'(NUM_ROUNDS);

  fsm_t               r_fsm;
  logic [BLOCK_W-1:0] r_state;
  logic [KIDX_W-1:0]  r_rnd;
  logic [KIDX_W-1:0]  r_kidx;
  logic               r_in_ready;
  logic               r_out_valid;

  logic [BLOCK_W-1:0] w_perm;
  logic [BLOCK_W-1:0] w_round;

  inv_player u_inv_player (
    .din  (r_state),
    .dout (w_perm)
  );

  assign w_round = inv_sbox64(w_perm) ^ key_i;

  // key_idx is kept as its own register so it changes on the same edge as the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= IDLE;
      r_state     <= '0;
      r_rnd       <= '0;
      r_kidx      <= c_kidx_first;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_state    <= in_data ^ key_i;
            r_rnd      <= c_kidx_run;
            r_kidx     <= c_kidx_run;
            r_in_ready <= 1'b0;
            r_fsm      <= RUN;
          end
        end
        RUN: begin
          r_state <= w_round;
          r_rnd   <= r_rnd - 1'b1;
          r_kidx  <= r_rnd - 1'b1;
          if (r_rnd == KIDX_W'(1)) begin
            r_out_valid <= 1'b1;
            r_fsm       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
`ifdef PRESENT_DEC_ZEROIZE_EN
            r_state     <= '0;
`endif
            r_kidx      <= c_kidx_first;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_fsm       <= IDLE;
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign key_idx   = r_kidx;

`ifdef PRESENT_DEC_ZEROIZE_EN
  assign out_data = r_out_valid ? r_state : '0;
`else
  assign out_data = r_state;
`endif

endmodule

`default_nettype wire

// File: tb/tb_present_dec_core.sv
// ============================================================================
// Module   : tb_present_dec_core
// Brief    : Scoreboard bench; plaintexts are encrypted with a PRESENT-80
//            model and the core must return them (PRESENT_DEC_ZEROIZE_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_present_dec_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, key_i, out_data;
  logic [5:0]  key_idx;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [63:0] s_in_data, s_out_data;
  logic [63:0] s_key_i;
  logic [5:0]  s_key_idx;

  logic [63:0] keys [0:63];
  logic [63:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          bp_hold;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign key_i   = keys[key_idx];
  assign s_key_i = 64'h0;

  present_dec_core u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .key_idx(key_idx), .key_i(key_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  present_dec_core #(.NUM_ROUNDS(1), .KIDX_W(6)) u_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .key_idx(s_key_idx), .key_i(s_key_i),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'hC56B90AD3EF84712;
    return tbl[(15 - int'(x)) * 4 +: 4];
  endfunction

  // PRESENT-80 key schedule: round keys 1..32 land at keys[1..32]
  task automatic load_keys(input logic [79:0] key);
    logic [79:0] k;
    k = key;
    for (int i = 0; i < 64; i++) keys[i] = '0;
    for (int i = 1; i <= 32; i++) begin
      keys[i]   = k[79:16];
      k         = {k[18:0], k[79:19]};
      k[79:76]  = sbox(k[79:76]);
      k[19:15]  = k[19:15] ^ 5'(i);
    end
  endtask

  function automatic logic [63:0] encrypt(input logic [63:0] pt);
    logic [63:0] s, t, p;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ keys[r];
      for (int n = 0; n < 16; n++) t[4*n +: 4] = sbox(s[4*n +: 4]);
      for (int b = 0; b < 63; b++) p[(16*b) % 63] = t[b];
      p[63] = t[63];
      s = p;
    end
    return s ^ keys[32];
  endfunction

  task automatic wait_accept();
    bit ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got no in_ready expected in_ready within 300 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: got busy expected idle within 500 cycles");
    end
  endtask

  task automatic send(input logic [63:0] ct, input logic [63:0] pt);
    @(posedge clk); #1;
    exp_q.push_back(pt);
    in_valid = 1'b1;
    in_data  = ct;
    wait_accept();
    in_valid = 1'b0;
    wait_idle();
  endtask

  // Monitor: tracks the expected protocol phase and pops the scoreboard on handoff
  bit          busy;
  int          acc, k;
  logic [63:0] last_pt;
  initial begin
    busy = 0; acc = 0; last_pt = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0; exp_q.delete(); last_pt = '0;
      end else if (!busy) begin
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        chk("idle_key_idx", 64'(key_idx), 64'd32);
`ifdef PRESENT_DEC_ZEROIZE_EN
        chk("idle_out_data", out_data, 64'd0);
`else
        chk("idle_out_data", out_data, last_pt);
`endif
        if (in_valid) begin busy = 1; acc = cyc; end
      end else begin
        k = cyc - acc;
        if (k < 32) begin
          chk("run_in_ready", 64'(in_ready), 64'd0);
          chk("run_out_valid", 64'(out_valid), 64'd0);
          chk("run_key_idx", 64'(key_idx), 64'(32 - k));
        end else begin
          chk("done_out_valid", 64'(out_valid), 64'd1);
          chk("done_in_ready", 64'(in_ready), 64'd0);
          chk("done_key_idx", 64'(key_idx), 64'd0);
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_empty: got out_data %h expected no output", out_data);
            busy = 0;
          end else begin
            chk("out_data", out_data, exp_q[0]);
            if (out_ready) begin
              last_pt = exp_q.pop_front();
              busy    = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    logic [79:0] key;
    logic [63:0] pt;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; bp_hold = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
    load_keys(80'h0);
    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_key_idx", 64'(key_idx), 64'd32);
    chk("rst_small_key_idx", 64'(s_key_idx), 64'd2);
    @(negedge clk); #1 rst_n = 1'b1;

    // one-round instance with all-zero keys
    @(posedge clk); #1;
    s_in_valid = 1'b1; s_in_data = '0;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    chk("smoke_run_valid", 64'(s_out_valid), 64'd0);
    chk("smoke_run_key_idx", 64'(s_key_idx), 64'd1);
    @(posedge clk); #1;
    chk("smoke_out_valid", 64'(s_out_valid), 64'd1);
    chk("smoke_out_data", s_out_data, 64'h5555555555555555);
    @(posedge clk); #1;
    chk("smoke_back_idle", 64'(s_in_ready), 64'd1);

    load_keys(80'h0);
    send(64'h5579C1387B228445, 64'h0);
    load_keys({80{1'b1}});
    send(64'hE72C46C0F5945049, 64'h0);

    // backpressure with in_valid held high across the handoff
    load_keys(80'h0);
    @(posedge clk); #1;
    bp_hold = 1'b1;
    exp_q.push_back(64'h0);
    exp_q.push_back(64'hFFFFFFFFFFFFFFFF);
    in_valid = 1'b1; in_data = 64'h5579C1387B228445;
    wait_accept();
    in_data = 64'hA112FFC72F68417B;
    for (int n = 0; n < 100 && !out_valid; n++) @(posedge clk);
    repeat (10) @(posedge clk);
    #1 bp_hold = 1'b0;
    wait_accept();
    in_valid = 1'b0;
    wait_idle();

    // reset during RUN discards the block
    key = {$urandom, $urandom, 16'($urandom)};
    load_keys(key);
    pt = {$urandom, $urandom};
    @(posedge clk); #1;
    exp_q.push_back(pt);
    in_valid = 1'b1; in_data = encrypt(pt);
    wait_accept();
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_key_idx", 64'(key_idx), 64'd32);
    chk("midrst_out_data", out_data, 64'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    send(encrypt(pt), pt);

    for (int i = 0; i < 6; i++) begin
      key = {$urandom, $urandom, 16'($urandom)};
      load_keys(key);
      pt = {$urandom, $urandom};
      send(encrypt(pt), pt);
    end

    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_leftover: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
